// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 32;

   // Value driven toward IF/ID whenever no valid word is available.
   localparam logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(0);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with load-target / increment / hold select and async reset.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              inc_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] pc_plus4_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   // Load wins over increment; otherwise hold.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = target_i;
      end else if (inc_i) begin
         pc_d = pc_q + ADDR_W'(4);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_q + ADDR_W'(4);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: single outstanding request to a variable-latency
// memory, redirect handling with stale-response drop, and stall hold buffer.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               StallF,
   input  logic               PCSrcE,
   input  logic [ADDR_W-1:0]  PCTargetE,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  PCF,
   output logic [ADDR_W-1:0]  PCPlus4F,
   output logic               FetchBubbleF
);

   fetch_state_t       state_q;
   fetch_state_t       state_d;
   logic [INSTR_W-1:0] hold_q;
   logic [INSTR_W-1:0] hold_d;
   logic               started_q;

   logic               pc_load;
   logic               pc_inc;
   logic               hold_load;
   logic               present_rdata;
   logic               present_hold;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  pc_plus4;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk        (clk),
      .rst        (rst),
      .load_i     (pc_load),
      .inc_i      (pc_inc),
      .target_i   (PCTargetE),
      .pc_o       (pc),
      .pc_plus4_o (pc_plus4)
   );

   // Keeps imem_req low until the first clock edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         started_q <= 1'b0;
      end else begin
         started_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_REQ;
         hold_q  <= BUBBLE_INSTR;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_load       = 1'b0;
      pc_inc        = 1'b0;
      hold_load     = 1'b0;
      imem_req      = 1'b0;
      present_rdata = 1'b0;
      present_hold  = 1'b0;

      case (state_q)
         S_REQ: begin
            if (started_q) begin
               imem_req = 1'b1;
               if (PCSrcE) begin
                  pc_load = 1'b1;
                  state_d = S_DROP;
               end else begin
                  state_d = S_WAIT;
               end
            end else if (PCSrcE) begin
               pc_load = 1'b1;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (PCSrcE) begin
                  pc_load = 1'b1;
                  state_d = S_REQ;
               end else if (StallF) begin
                  present_rdata = 1'b1;
                  hold_load     = 1'b1;
                  state_d       = S_HOLD;
               end else begin
                  present_rdata = 1'b1;
                  pc_inc        = 1'b1;
                  state_d       = S_REQ;
               end
            end else if (PCSrcE) begin
               pc_load = 1'b1;
               state_d = S_DROP;
            end
         end
         S_HOLD: begin
            present_hold = 1'b1;
            if (PCSrcE) begin
               pc_load = 1'b1;
               state_d = S_REQ;
            end else if (!StallF) begin
               pc_inc  = 1'b1;
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            // A newer redirect only retargets the PC; the stale response is still owed.
            if (PCSrcE) begin
               pc_load = 1'b1;
            end
            if (imem_rvalid) begin
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   assign hold_d = hold_load ? imem_rdata : hold_q;

   assign imem_addr    = pc;
   assign PCF          = pc;
   assign PCPlus4F     = pc_plus4;
   assign instruction  = present_rdata ? imem_rdata
                       : present_hold  ? hold_q
                       : BUBBLE_INSTR;
   assign FetchBubbleF = ~(present_rdata | present_hold);

`ifndef SYNTHESIS
   // Responses may only arrive while a request is outstanding.
   a_no_unsolicited_rvalid : assert property (
      @(posedge clk) disable iff (rst)
      !(imem_rvalid && ((state_q == S_REQ) || (state_q == S_HOLD)))
   ) else $error("imem_rvalid with no request outstanding");
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset corner
// case, then randomized traffic against a transaction-level reference model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        StallF;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;
   logic        FetchBubbleF;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .StallF       (StallF),
      .PCSrcE       (PCSrcE),
      .PCTargetE    (PCTargetE),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .instruction  (instruction),
      .PCF          (PCF),
      .PCPlus4F     (PCPlus4F),
      .FetchBubbleF (FetchBubbleF)
   );

   // Memory: one outstanding request, fixed per-request latency.
   logic        mem_busy = 1'b0;
   int          mem_due  = 0;
   logic [31:0] mem_addr = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h8) return 32'hDEAD_BEEF;
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag, input logic req, input logic [31:0] pc,
                                input logic [31:0] instr, input logic bub);
      chk({tag, " imem_req"},     32'(imem_req),     32'(req));
      chk({tag, " imem_addr"},    imem_addr,         pc);
      chk({tag, " PCF"},          PCF,               pc);
      chk({tag, " PCPlus4F"},     PCPlus4F,          pc + 32'd4);
      chk({tag, " instruction"},  instruction,       instr);
      chk({tag, " FetchBubbleF"}, 32'(FetchBubbleF), 32'(bub));
   endtask

   // Drive one cycle's inputs (at posedge+1) and advance to the sampling point.
   task automatic drive(input logic stall, input logic src, input logic [31:0] tgt);
      logic rv;
      rv = 1'b0;
      if (mem_busy) begin
         mem_due--;
         if (mem_due == 0) begin
            rv       = 1'b1;
            mem_busy = 1'b0;
         end
      end
      StallF      = stall;
      PCSrcE      = src;
      PCTargetE   = tgt;
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(mem_addr) : $urandom();
      @(negedge clk);
   endtask

   task automatic finish_cycle(input logic req, input logic [31:0] addr, input int lat);
      if (req) begin
         mem_busy = 1'b1;
         mem_due  = lat;
         mem_addr = addr;
      end
      @(posedge clk);
      #1;
   endtask

   // Reference model: PC, whether a request is in flight, whether that request
   // is stale, and whether a stalled word is being held.
   logic [31:0] m_pc;
   logic        m_started, m_out, m_stale, m_hold;
   logic [31:0] m_hword;

   task automatic model_reset();
      m_pc = 32'h0; m_started = 1'b0; m_out = 1'b0; m_stale = 1'b0;
      m_hold = 1'b0; m_hword = 32'h0;
   endtask

   task automatic model_step(input logic stall, input logic src, input logic rv,
                             input logic [31:0] tgt, input logic [31:0] rdata,
                             output logic req, output logic [31:0] pc,
                             output logic [31:0] instr, output logic bub);
      req   = m_started && !m_out && !m_hold;
      pc    = m_pc;
      instr = 32'h0;
      bub   = 1'b1;
      if (m_hold) begin
         instr = m_hword; bub = 1'b0;
      end else if (m_out && !m_stale && rv && !src) begin
         instr = rdata; bub = 1'b0;
      end
      if (!m_started) begin
         if (src) m_pc = tgt;
      end else if (req) begin
         m_out = 1'b1; m_stale = src;
         if (src) m_pc = tgt;
      end else if (m_hold) begin
         if (src) begin
            m_pc = tgt; m_hold = 1'b0;
         end else if (!stall) begin
            m_pc = m_pc + 32'd4; m_hold = 1'b0;
         end
      end else if (rv) begin
         m_out = 1'b0;
         if (src) m_pc = tgt;
         else if (!m_stale) begin
            if (stall) begin
               m_hold = 1'b1; m_hword = rdata;
            end else begin
               m_pc = m_pc + 32'd4;
            end
         end
      end else if (src) begin
         m_pc = tgt; m_stale = 1'b1;
      end
      m_started = 1'b1;
   endtask

   typedef struct {
      logic        stall;
      logic        src;
      logic [31:0] tgt;
      int          lat;
      logic        req;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        bub;
   } vec_t;

   vec_t vt[$];

   initial begin
      logic        e_req, e_bub, stall, src;
      logic [31:0] e_pc, e_instr, tgt;
      int          lat;

      vt.push_back('{1'b0, 1'b0, 32'h0,         1, 1'b0, 32'h0,         32'h0,         1'b1});
      vt.push_back('{1'b0, 1'b0, 32'h0,         1, 1'b1, 32'h0,         32'h0,         1'b1});
      vt.push_back('{1'b0, 1'b0, 32'h0,         1, 1'b0, 32'h0,         32'h0050_0093, 1'b0});
      vt.push_back('{1'b0, 1'b0, 32'h0,         3, 1'b1, 32'h4,         32'h0,         1'b1});
      vt.push_back('{1'b1, 1'b0, 32'h0,         1, 1'b0, 32'h4,         32'h0,         1'b1});
      vt.push_back('{1'b0, 1'b0, 32'h0,         1, 1'b0, 32'h4,         32'h0,         1'b1});
      vt.push_back('{1'b0, 1'b0, 32'h0,         1, 1'b0, 32'h4,         32'hA5A5_0004, 1'b0});
      vt.push_back('{1'b0, 1'b0, 32'h0,         1, 1'b1, 32'h8,         32'h0,         1'b1});
      vt.push_back('{1'b1, 1'b0, 32'h0,         1, 1'b0, 32'h8,         32'hDEAD_BEEF, 1'b0});
      vt.push_back('{1'b1, 1'b0, 32'h0,         1, 1'b0, 32'h8,         32'hDEAD_BEEF, 1'b0});
      vt.push_back('{1'b1, 1'b0, 32'h0,         1, 1'b0, 32'h8,         32'hDEAD_BEEF, 1'b0});
      vt.push_back('{1'b0, 1'b0, 32'h0,         1, 1'b0, 32'h8,         32'hDEAD_BEEF, 1'b0});
      vt.push_back('{1'b0, 1'b0, 32'h0,         2, 1'b1, 32'hC,         32'h0,         1'b1});
      vt.push_back('{1'b0, 1'b1, 32'h100,       1, 1'b0, 32'hC,         32'h0,         1'b1});
      vt.push_back('{1'b0, 1'b0, 32'h0,         1, 1'b0, 32'h100,       32'h0,         1'b1});
      vt.push_back('{1'b0, 1'b0, 32'h0,         1, 1'b1, 32'h100,       32'h0,         1'b1});
      vt.push_back('{1'b0, 1'b1, 32'h200,       1, 1'b0, 32'h100,       32'h0,         1'b1});
      vt.push_back('{1'b0, 1'b1, 32'hFFFF_FFFC, 1, 1'b1, 32'h200,       32'h0,         1'b1});
      vt.push_back('{1'b0, 1'b0, 32'h0,         1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1});
      vt.push_back('{1'b0, 1'b0, 32'h0,         1, 1'b1, 32'hFFFF_FFFC, 32'h0,         1'b1});
      vt.push_back('{1'b0, 1'b0, 32'h0,         1, 1'b0, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b0});
      vt.push_back('{1'b0, 1'b0, 32'h0,         3, 1'b1, 32'h0,         32'h0,         1'b1});
      vt.push_back('{1'b0, 1'b0, 32'h0,         1, 1'b0, 32'h0,         32'h0,         1'b1});

      rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
      imem_rvalid = 1'b0; imem_rdata = 32'h0;
      #1;
      check_outputs("reset", 1'b0, 32'h0, 32'h0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (vt[i]) begin
         drive(vt[i].stall, vt[i].src, vt[i].tgt);
         check_outputs($sformatf("vec%0d", i), vt[i].req, vt[i].pc, vt[i].instr, vt[i].bub);
         finish_cycle(vt[i].req, vt[i].pc, vt[i].lat);
      end

      // Reset while a 3-cycle request is outstanding: outputs return immediately.
      rst = 1'b1;
      StallF = 1'b0; PCSrcE = 1'b0; imem_rvalid = 1'b0;
      mem_busy = 1'b0;
      #1;
      check_outputs("mid_reset", 1'b0, 32'h0, 32'h0, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      for (int n = 0; n < 3000; n++) begin
         stall = ($urandom_range(0, 3) == 0);
         src   = ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 3))
            0:       tgt = 32'hFFFF_FFFC;
            1:       tgt = 32'hFFFF_FFF8;
            default: tgt = $urandom() & 32'hFFFF_FFFC;
         endcase
         lat = $urandom_range(1, 4);
         drive(stall, src, tgt);
         model_step(stall, src, imem_rvalid, tgt, imem_rdata, e_req, e_pc, e_instr, e_bub);
         check_outputs($sformatf("rand%0d", n), e_req, e_pc, e_instr, e_bub);
         finish_cycle(e_req, e_pc, lat);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
